fft_addr_gen: RTL and testbench

Butterfly address/twiddle sequencer for the in-place radix-2 DIT FFT datapath. One start pulse walks all LOG2N stages × N/2 butterflies. For each butterfly it emits the operand address pair (a, b), the twiddle index and the stage number. The stage output drives the S select of the 5-bit index rotation stage directly downstream; the addresses drive the memory read/write ports.

---
 rtl/fft_addr_gen_pkg.sv | 17 +
 rtl/fft_bfly_addr_calc.sv | 35 +++
 rtl/fft_addr_gen.sv | 151 +++++++++++++++
 tb/tb_fft_addr_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_addr_gen_pkg.sv
// Shared constants for the radix-2 DIT FFT datapath: transform size, stage
// field width (also used by the index rotation stage) and sequencer states.
package fft_addr_gen_pkg;

  localparam int FFT_LOG2N = 5;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int FFT_TWW   = FFT_LOG2N - 1;
  // Must satisfy 2**FFT_SW > FFT_LOG2N-1 so every stage number fits.
  localparam int FFT_SW    = 3;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fft_bfly_addr_calc.sv
// Combinational butterfly address/twiddle mapping for one (stage, index) pair:
// h = 2^s, g = j>>s, p = j&(h-1); a = g*2h + p, b = a + h, tw = p << (LOG2N-1-s).
module fft_bfly_addr_calc
  import fft_addr_gen_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int TWW   = LOG2N - 1,
  parameter int SW    = FFT_SW
) (
  input  logic [SW-1:0]    s_i,
  input  logic [TWW-1:0]   j_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [TWW-1:0]   tw_idx_o
);

  logic [LOG2N-1:0] h;
  logic [LOG2N-1:0] j_w;
  logic [LOG2N-1:0] g_base;
  logic [TWW-1:0]   p;
  logic [SW-1:0]    tw_sh;

  always_comb begin
    h        = LOG2N'(1) << s_i;
    j_w      = LOG2N'(j_i);
    p        = j_i & TWW'(h - LOG2N'(1));
    // Clearing the low s bits and doubling gives g*2h without a multiplier.
    g_base   = ((j_w >> s_i) << s_i) << 1;
    addr_a_o = g_base | LOG2N'(p);
    addr_b_o = addr_a_o + h;
    tw_sh    = SW'(TWW) - s_i;
    tw_idx_o = p << tw_sh;
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle sequencer: one start pulse walks LOG2N stages of
// N/2 butterflies, one registered beat per transfer, with valid/ready stall.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | issuing beats; counters (s,j) point at the next beat to load
//   DONE    | one-cycle done pulse, then back to IDLE
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int TWW   = LOG2N - 1,
  parameter int SW    = FFT_SW
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             start_i,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [TWW-1:0]   tw_idx_o,
  output logic [SW-1:0]    stage_o,
  output logic             last_o,
  output logic             done_o
);

  fsm_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [TWW-1:0]   tw_q, tw_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [TWW-1:0]   j_q, j_d;
  logic [SW-1:0]    s_q, s_d;

  logic [LOG2N-1:0] calc_a, calc_b;
  logic [TWW-1:0]   calc_tw;
  logic             j_last, s_last;

  fft_bfly_addr_calc #(
    .LOG2N (LOG2N),
    .TWW   (TWW),
    .SW    (SW)
  ) u_calc (
    .s_i      (s_q),
    .j_i      (j_q),
    .addr_a_o (calc_a),
    .addr_b_o (calc_b),
    .tw_idx_o (calc_tw)
  );

  assign j_last = (j_q == {TWW{1'b1}});
  assign s_last = (s_q == SW'(LOG2N - 1));

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_d     = tw_q;
    stage_d  = stage_q;
    j_d      = j_q;
    s_d      = s_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          j_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        // Load a fresh beat when the output register is empty or being drained.
        if (!valid_q || out_ready_i) begin
          if (valid_q && last_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            valid_d  = 1'b1;
            addr_a_d = calc_a;
            addr_b_d = calc_b;
            tw_d     = calc_tw;
            stage_d  = s_q;
            last_d   = j_last && s_last;
            if (j_last) begin
              j_d = '0;
              s_d = s_q + SW'(1);
            end else begin
              j_d = j_q + TWW'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
      j_q      <= '0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      stage_q  <= stage_d;
      j_q      <= j_d;
      s_q      <= s_d;
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;
  assign tw_idx_o    = tw_q;
  assign stage_o     = stage_q;
  assign last_o      = last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: full runs, stall, ignored restarts and
// mid-run async clear, checked against an independently built beat table.
module tb_fft_addr_gen;

  localparam int LOG2N = 5;
  localparam int N     = 32;
  localparam int TWW   = 4;
  localparam int SW    = 3;
  localparam int BEATS = LOG2N * N / 2;

  logic             clk_i = 1'b0;
  logic             clr_n_i = 1'b1;
  logic             start_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             busy_o;
  logic             out_valid_o;
  logic [LOG2N-1:0] addr_a_o;
  logic [LOG2N-1:0] addr_b_o;
  logic [TWW-1:0]   tw_idx_o;
  logic [SW-1:0]    stage_o;
  logic             last_o;
  logic             done_o;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_a [BEATS];
  int exp_b [BEATS];
  int exp_tw[BEATS];
  int exp_s [BEATS];
  int exp_l [BEATS];
  int got_a [BEATS];
  int got_b [BEATS];
  int got_tw[BEATS];
  int got_s [BEATS];
  int got_l [BEATS];

  int beats, dones, done_cyc, nlast;

  fft_addr_gen dut (
    .clk_i       (clk_i),
    .clr_n_i     (clr_n_i),
    .start_i     (start_i),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .addr_a_o    (addr_a_o),
    .addr_b_o    (addr_b_o),
    .tw_idx_o    (tw_idx_o),
    .stage_o     (stage_o),
    .last_o      (last_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] snap_outs();
    return 32'({addr_a_o, addr_b_o, tw_idx_o, stage_o, last_o, out_valid_o});
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy_o),      0);
    check({tag, "_valid"},  32'(out_valid_o), 0);
    check({tag, "_addr_a"}, 32'(addr_a_o),    0);
    check({tag, "_addr_b"}, 32'(addr_b_o),    0);
    check({tag, "_tw"},     32'(tw_idx_o),    0);
    check({tag, "_stage"},  32'(stage_o),     0);
    check({tag, "_last"},   32'(last_o),      0);
    check({tag, "_done"},   32'(done_o),      0);
  endtask

  // Starts a run and walks it for a fixed cycle window. Cycle 0 is the sample
  // just after the edge that saw start.
  task automatic run_seq(input int stall_at, input int stall_len, input int rs_a,
                         input int rs_b, input bit rs_done, input int abort_at,
                         output int nbeats, output int ndone, output int dcyc);
    int stalled;
    bit aborted;
    logic [31:0] snap;
    nbeats = 0; ndone = 0; dcyc = -1; stalled = 0; aborted = 1'b0; snap = '0;
    out_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 1);
    check("valid_latency1", 32'(out_valid_o), 0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      start_i = 1'b0;
      if (done_o) begin
        ndone++;
        dcyc = cyc;
        check("busy_falls_with_done", 32'(busy_o), 0);
        if (rs_done) start_i = 1'b1;
      end
      if (out_valid_o && nbeats == abort_at) begin
        #2 clr_n_i = 1'b0;
        #1;
        check_all_zero("async_clear");
        aborted = 1'b1;
      end else if (out_valid_o) begin
        if (nbeats == rs_a || nbeats == rs_b) start_i = 1'b1;
        if (nbeats == stall_at && stalled < stall_len) begin
          if (stalled == 0) snap = snap_outs();
          else check("stall_hold", snap_outs(), snap);
          stalled++;
          out_ready_i = 1'b0;
        end else begin
          if (stalled > 0 && nbeats == stall_at) check("stall_resume", snap_outs(), snap);
          if (nbeats < BEATS) begin
            check("beat_addr_a", 32'(addr_a_o), 32'(exp_a[nbeats]));
            check("beat_addr_b", 32'(addr_b_o), 32'(exp_b[nbeats]));
            check("beat_tw_idx", 32'(tw_idx_o), 32'(exp_tw[nbeats]));
            check("beat_stage",  32'(stage_o),  32'(exp_s[nbeats]));
            check("beat_last",   32'(last_o),   32'(exp_l[nbeats]));
            got_a[nbeats]  = int'(addr_a_o);
            got_b[nbeats]  = int'(addr_b_o);
            got_tw[nbeats] = int'(tw_idx_o);
            got_s[nbeats]  = int'(stage_o);
            got_l[nbeats]  = int'(last_o);
          end else begin
            check("extra_beat", 32'(nbeats), BEATS - 1);
          end
          nbeats++;
          out_ready_i = 1'b1;
        end
      end else begin
        out_ready_i = 1'b1;
      end
      if (aborted) break;
      tick();
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
  endtask

  initial begin
    // Reference table: stage by stage, group base then offset within group.
    begin
      int k;
      k = 0;
      for (int s = 0; s < LOG2N; s++) begin
        for (int grp = 0; grp < N; grp += 2 << s) begin
          for (int p = 0; p < (1 << s); p++) begin
            exp_a[k]  = grp + p;
            exp_b[k]  = grp + p + (1 << s);
            exp_tw[k] = p * ((N / 2) >> s);
            exp_s[k]  = s;
            exp_l[k]  = (k == BEATS - 1) ? 1 : 0;
            k++;
          end
        end
      end
    end

    #2 clr_n_i = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    clr_n_i = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy_o), 0);
    check("idle_valid", 32'(out_valid_o), 0);

    // Plain run with ready held high.
    run_seq(-1, 0, -1, -1, 1'b0, -1, beats, dones, done_cyc);
    check("run1_beats", 32'(beats), BEATS);
    check("run1_dones", 32'(dones), 1);
    check("run1_done_cycle", 32'(done_cyc), 81);
    check("first_addr_a", 32'(got_a[0]), 0);
    check("first_addr_b", 32'(got_b[0]), 1);
    check("first_tw", 32'(got_tw[0]), 0);
    check("first_stage", 32'(got_s[0]), 0);
    check("s2j5_addr_a", 32'(got_a[37]), 9);
    check("s2j5_addr_b", 32'(got_b[37]), 13);
    check("s2j5_tw", 32'(got_tw[37]), 4);
    check("s2j5_stage", 32'(got_s[37]), 2);
    check("s1j3_addr_a", 32'(got_a[19]), 5);
    check("s1j3_addr_b", 32'(got_b[19]), 7);
    check("s1j3_tw", 32'(got_tw[19]), 8);
    check("s1j3_stage", 32'(got_s[19]), 1);
    check("final_addr_a", 32'(got_a[79]), 15);
    check("final_addr_b", 32'(got_b[79]), 31);
    check("final_tw", 32'(got_tw[79]), 15);
    check("final_stage", 32'(got_s[79]), 4);
    check("final_last", 32'(got_l[79]), 1);
    nlast = 0;
    for (int i = 0; i < BEATS; i++) nlast += got_l[i];
    check("last_count", 32'(nlast), 1);

    // Three-cycle stall on beat 7.
    repeat (2) tick();
    run_seq(7, 3, -1, -1, 1'b0, -1, beats, dones, done_cyc);
    check("stall_beats", 32'(beats), BEATS);
    check("stall_dones", 32'(dones), 1);
    check("stall_done_cycle", 32'(done_cyc), 84);

    // Start re-pulsed while busy and in DONE.
    repeat (2) tick();
    run_seq(-1, 0, 10, 79, 1'b1, -1, beats, dones, done_cyc);
    check("restart_beats", 32'(beats), BEATS);
    check("restart_dones", 32'(dones), 1);
    check("restart_done_cycle", 32'(done_cyc), 81);
    check("restart_idle_busy", 32'(busy_o), 0);
    check("restart_idle_valid", 32'(out_valid_o), 0);

    // Asynchronous clear at beat 40.
    repeat (2) tick();
    run_seq(-1, 0, -1, -1, 1'b0, 40, beats, dones, done_cyc);
    check("abort_beats", 32'(beats), 40);
    check("abort_no_done", 32'(dones), 0);
    repeat (2) tick();
    check("abort_hold_done", 32'(done_o), 0);
    clr_n_i = 1'b1;
    repeat (2) tick();
    check("after_abort_busy", 32'(busy_o), 0);
    check("after_abort_valid", 32'(out_valid_o), 0);

    // Fresh run after the clear restarts from stage 0, j 0.
    run_seq(-1, 0, -1, -1, 1'b0, -1, beats, dones, done_cyc);
    check("rerun_beats", 32'(beats), BEATS);
    check("rerun_dones", 32'(dones), 1);
    check("rerun_done_cycle", 32'(done_cyc), 81);
    check("rerun_first_stage", 32'(got_s[0]), 0);
    check("rerun_first_addr_b", 32'(got_b[0]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
